muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Computes MIPS MULT/MULTU/DIV/DIVU over multiple cycles and holds the HI/LO register pair.
- The EX-stage mux reads hi/lo to serve MFHI/MFLO.
- Asserts busy so the hazard unit stalls any MFHI/MFLO issued before the result is ready.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sign_fix.sv | 12 +
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and constants for muldiv_unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_e;

    localparam int MAX_WIDTH = 64;

    // Quotient reported on divide-by-zero; sliced to WIDTH by the user.
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - combinational conditional two's-complement negate (abs / sign restore)
module muldiv_sign_fix #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + N'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MULDIV_EARLY_OUT_EN enables multiply early-out
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_div_by_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_div0;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_mcand;
    logic [W2-1:0]    r_acc;
    logic [WIDTH-1:0] r_opb;

    op_e              w_op;
    logic             w_is_div;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [W2-1:0]    w_mul_sum;
    logic             w_last_iter;
    logic             w_mul_last;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [W2-1:0]    w_fix_in;
    logic [W2-1:0]    w_fix_lo;
    logic [WIDTH-1:0] w_fix_rem;

    assign w_op     = op_e'(op);
    assign w_is_div = (w_op == OP_DIVU) || (w_op == OP_DIV);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

    muldiv_sign_fix #(.N(WIDTH)) u_abs_a (
        .i_val (a),
        .i_neg (w_signed & a[WIDTH-1]),
        .o_val (w_abs_a)
    );

    muldiv_sign_fix #(.N(WIDTH)) u_abs_b (
        .i_val (b),
        .i_neg (w_signed & b[WIDTH-1]),
        .o_val (w_abs_b)
    );

    // Multiply: accumulate the left-shifting multiplicand for each set multiplier bit.
    assign w_mul_sum   = r_acc + (r_opb[0] ? r_mcand : {W2{1'b0}});
    assign w_last_iter = (r_cnt == CW'(1));

`ifdef MULDIV_EARLY_OUT_EN
    // Product is already aligned once no higher multiplier bits remain.
    assign w_mul_last = w_last_iter || (r_opb[WIDTH-1:1] == '0);
`else
    assign w_mul_last = w_last_iter;
`endif

    // Divide: r_acc holds {remainder, dividend/quotient}, shifted left one bit per step.
    assign w_div_shift = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_rem_next  = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    assign w_quo_next  = {r_acc[WIDTH-2:0], ~w_div_diff[WIDTH]};

    assign w_fix_in = r_is_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;

    muldiv_sign_fix #(.N(W2)) u_fix_lo (
        .i_val (w_fix_in),
        .i_neg (r_neg_lo),
        .o_val (w_fix_lo)
    );

    muldiv_sign_fix #(.N(WIDTH)) u_fix_rem (
        .i_val (r_acc[W2-1:WIDTH]),
        .i_neg (r_neg_hi),
        .o_val (w_fix_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_is_div      <= 1'b0;
            r_div0        <= 1'b0;
            r_neg_lo      <= 1'b0;
            r_neg_hi      <= 1'b0;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_acc         <= '0;
            r_opb         <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_busy   <= 1'b1;
                            r_cnt    <= CW'(WIDTH);
                            r_is_div <= w_is_div;
                            r_div0   <= 1'b0;
                            r_neg_lo <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_hi <= w_signed & a[WIDTH-1];
                            r_opb    <= w_abs_b;
                            if (!w_is_div) begin
                                r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
                                r_acc   <= '0;
                                r_state <= MUL;
                            end else if (b == '0) begin
                                // Raw dividend parked in the remainder half for hi.
                                r_div0  <= 1'b1;
                                r_acc   <= {a, {WIDTH{1'b0}}};
                                r_state <= FIX;
                            end else begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                r_state <= DIV;
                            end
                        end
                    end
                    MUL: begin
                        r_acc   <= w_mul_sum;
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                        r_cnt   <= r_cnt - CW'(1);
                        if (w_mul_last) begin
                            r_state <= FIX;
                        end
                    end
                    DIV: begin
                        r_acc <= {w_rem_next, w_quo_next};
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last_iter) begin
                            r_state <= FIX;
                        end
                    end
                    FIX: begin
                        if (r_div0) begin
                            r_hi          <= r_acc[W2-1:WIDTH];
                            r_lo          <= DIV0_QUOTIENT[WIDTH-1:0];
                            r_div_by_zero <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi          <= w_fix_rem;
                            r_lo          <= w_fix_lo[WIDTH-1:0];
                            r_div_by_zero <= 1'b0;
                        end else begin
                            r_hi          <= w_fix_lo[W2-1:WIDTH];
                            r_lo          <= w_fix_lo[WIDTH-1:0];
                            r_div_by_zero <= 1'b0;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] h, output logic [31:0] l, output logic dz);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        p  = '0;
        if (o[1] && y == 32'd0) begin
            h  = x;
            l  = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            case (o)
                2'b00: p = {32'd0, x} * {32'd0, y};
                2'b01: p = 64'(sx * sy);
                2'b10: p = {x % y, x / y};
                default: p = {32'(sx % sy), 32'(sx / sy)};
            endcase
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        int nbits;
        if (o[1]) return (y == 32'd0) ? 2 : 34;
        m = (o[0] && y[31]) ? (~y + 32'd1) : y;
        nbits = 32;
`ifdef MULDIV_EARLY_OUT_EN
        nbits = 1;
        for (int i = 0; i < 32; i++) if (m[i]) nbits = i + 1;
`endif
        return nbits + 2;
    endfunction

    // Launch one op from IDLE (caller sits 1ns after an edge) and observe until done or timeout.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l, output logic dz,
                         output int lat, output int busy_bad);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(posedge clk); #1;
        end
        h = hi; l = lo; dz = div_by_zero;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] h, l, eh, el;
        logic dz, edz;
        int lat, bb;
        do_op(o, x, y, h, l, dz, lat, bb);
        ref_model(o, x, y, eh, el, edz);
        n_vec += 5;
        if (h !== eh) begin n_err++; $display("FAIL %s hi got %h exp %h (op=%0d a=%h b=%h)", name, h, eh, o, x, y); end
        if (l !== el) begin n_err++; $display("FAIL %s lo got %h exp %h (op=%0d a=%h b=%h)", name, l, el, o, x, y); end
        if (dz !== edz) begin n_err++; $display("FAIL %s div_by_zero got %b exp %b", name, dz, edz); end
        if (lat !== exp_lat(o, y)) begin n_err++; $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat(o, y)); end
        if (bb !== 0) begin n_err++; $display("FAIL %s busy profile wrong in %0d cycles exp 0", name, bb); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
            n_err++;
            $display("FAIL reset outputs got %b/%b/%b %h %h exp all zero", busy, done, div_by_zero, hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("mult_neg", 2'b01, 32'hFFFF_FFF9, 32'd6);
        check_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        check_op("divu_zero", 2'b10, 32'd100, 32'd0);
        check_op("divu_7", 2'b10, 32'd100, 32'd7);
        check_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("div_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0);
        check_op("multu_9x1", 2'b00, 32'd9, 32'd1);
        check_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000);
        check_op("div_rem_neg", 2'b11, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [31:0] x, y;
        int sel;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: y = $urandom;
            endcase
            check_op("random", o, x, y);
        end
    endtask

    task automatic test_flush();
        logic [31:0] h, l, ph, pl;
        logic dz, pdz;
        int lat, bb, pulses;
        do_op(2'b00, 32'h1234, 32'h10, h, l, dz, lat, bb);
        ph = hi; pl = lo; pdz = div_by_zero;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        n_vec++;
        if ({hi, lo} !== {ph, pl}) begin n_err++; $display("FAIL flush hold_mid got %h_%h exp %h_%h", hi, lo, ph, pl); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL flush busy_done got %b%b exp 00", busy, done); end
        pulses = 0;
        repeat (40) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        n_vec += 2;
        if (pulses !== 0) begin n_err++; $display("FAIL flush done_pulses got %0d exp 0", pulses); end
        if ({hi, lo, div_by_zero} !== {ph, pl, pdz}) begin
            n_err++; $display("FAIL flush hold_after got %h_%h %b exp %h_%h %b", hi, lo, div_by_zero, ph, pl, pdz);
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] x, y, eh, el, gh, gl;
        logic edz;
        int pulses;
        x = $urandom; y = $urandom;
        ref_model(2'b00, x, y, eh, el, edz);
        start = 1'b1; op = 2'b00; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        gh = '0; gl = '0;
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 5) begin start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3; end
            if (c == 6) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) begin gh = hi; gl = lo; end
            end
            @(posedge clk); #1;
        end
        n_vec += 2;
        if (pulses !== 1) begin n_err++; $display("FAIL busy_start done_pulses got %0d exp 1", pulses); end
        if ({gh, gl} !== {eh, el}) begin n_err++; $display("FAIL busy_start result got %h_%h exp %h_%h", gh, gl, eh, el); end
    endtask

    task automatic test_flush_over_start();
        int pulses;
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL flush_prio busy got %b exp 0", busy); end
        pulses = 0;
        repeat (40) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (pulses !== 0) begin n_err++; $display("FAIL flush_prio done_pulses got %0d exp 0", pulses); end
    endtask

    task automatic test_async_reset();
        logic [31:0] h, l;
        logic dz;
        int lat, bb;
        do_op(2'b10, 32'd5, 32'd0, h, l, dz, lat, bb);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
            n_err++;
            $display("FAIL async_reset outputs got %b/%b/%b %h %h exp all zero", busy, done, div_by_zero, hi, lo);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_op("after_reset", 2'b00, 32'd2, 32'd3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_while_busy();
        test_flush_over_start();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
